uart_mmio: RTL and testbench

Memory-mapped 8N1 UART peripheral on the picorv32 native memory bus, alongside ROM, RAM, char RAM and LED. Drives `ftdi_rxd` and samples `ftdi_txd` so firmware gets a serial console. The block generates its own single-cycle `ready` pulse per access, which the top-level ORs into `mem_ready`. Fully synchronous to one clock with a 4-entry receive FIFO and a one-byte transmit holding register.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_mmio.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, TX/RX state encodings and the divisor floor.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO, DEPTH a power of two; pop data is the registered head.
// Latency 1 cycle push-to-visible; push while full is ignored unless a pop frees a slot.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] pop_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// 8N1 UART on the picorv32 native bus: one-byte TX holding register, RX FIFO, STATUS/DIV regs.
// Every access completes with a one-cycle ready the cycle after cs; a TX write while full is dropped.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIV = 217,
  parameter int RX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic [3:0]  we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        rxd,
  output logic        txd
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_pop_q, rd_pop_d;
  logic [15:0] div_q, div_d, div_new;
  logic        overrun_q, overrun_d, frame_q, frame_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_q, hold_d;

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d, tx_take;

  logic        rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_overrun_set, rx_frame_set;

  logic        acc, hold_wr, status_wr, div_wr;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dat;
  logic [31:0] status_rd;
  logic        unused_bits;

  assign unused_bits = ^wdata[31:16];
  assign ready = ready_q;
  assign rdata = rdata_q;
  assign txd   = txd_q;

  // Register side effects land in the ready cycle, so each access acts exactly once.
  assign acc       = cs && ready_q;
  assign hold_wr   = acc && (addr == REG_DATA) && we[0] && !hold_full_q;
  assign status_wr = acc && (addr == REG_STATUS) && we[0];
  assign div_wr    = acc && (addr == REG_DIV) && (|we[1:0]);
  assign fifo_pop  = acc && rd_pop_q;

  uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (rx_shift_q),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    status_rd                = '0;
    status_rd[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
    status_rd[ST_TX_FULL]    = hold_full_q;
    status_rd[ST_RX_VALID]   = !fifo_empty;
    status_rd[ST_RX_OVERRUN] = overrun_q;
    status_rd[ST_FRAME_ERR]  = frame_q;

    ready_d  = cs && !ready_q;
    rdata_d  = rdata_q;
    rd_pop_d = rd_pop_q;
    // Read data and the pop decision are captured together so the popped byte is the one returned.
    if (cs && !ready_q) begin
      rd_pop_d = 1'b0;
      case (addr)
        REG_DATA: begin
          rdata_d  = fifo_empty ? 32'hFFFF_FFFF : {24'h0, fifo_dat};
          rd_pop_d = !fifo_empty && (we == 4'b0000);
        end
        REG_STATUS: rdata_d = status_rd;
        REG_DIV:    rdata_d = {16'h0, div_q};
        default:    rdata_d = 32'h0;
      endcase
    end

    div_new = {we[1] ? wdata[15:8] : div_q[15:8], we[0] ? wdata[7:0] : div_q[7:0]};
    div_d   = div_q;
    if (div_wr) begin
      div_d = (div_new < MIN_DIV) ? MIN_DIV : div_new;
    end

    overrun_d = overrun_q;
    frame_d   = frame_q;
    if (status_wr && wdata[ST_RX_OVERRUN]) overrun_d = 1'b0;
    if (status_wr && wdata[ST_FRAME_ERR])  frame_d   = 1'b0;
    if (rx_overrun_set) overrun_d = 1'b1;
    if (rx_frame_set)   frame_d   = 1'b1;
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_take     = 1'b0;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    case (tx_state_q)
      TX_IDLE: tx_take = hold_full_q;
      TX_START: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_take    = hold_full_q;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
    endcase
    // Loading straight from STOP keeps back-to-back frames gapless.
    if (tx_take) begin
      tx_state_d  = TX_START;
      tx_cnt_d    = '0;
      tx_div_d    = div_q;
      tx_shift_d  = hold_q;
      hold_full_d = 1'b0;
    end
    if (hold_wr) begin
      hold_full_d = 1'b1;
      hold_d      = wdata[7:0];
    end
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_sync1_d     = rxd;
    rx_sync2_d     = rx_sync1_q;
    rx_prev_d      = rx_sync2_q;
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q + 16'd1;
    rx_div_d       = rx_div_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    fifo_push      = 1'b0;
    rx_overrun_set = 1'b0;
    rx_frame_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RX_START;
          rx_div_d   = div_q;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_state_d     = RX_IDLE;
          fifo_push      = rx_sync2_q && !fifo_full;
          rx_overrun_set = rx_sync2_q && fifo_full;
          rx_frame_set   = !rx_sync2_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      rd_pop_q    <= 1'b0;
      div_q       <= 16'(DEFAULT_DIV);
      overrun_q   <= 1'b0;
      frame_q     <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= 16'(DEFAULT_DIV);
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= 16'(DEFAULT_DIV);
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
    end else begin
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      rd_pop_q    <= rd_pop_d;
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_q     <= frame_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      rx_sync1_q  <= rx_sync1_d;
      rx_sync2_q  <= rx_sync2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: bus reads and serial TX frames are queued as expectations
// and checked by independent monitors watching ready and txd.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst_n, cs, rxd;
  logic [3:0]  we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ready, txd;

  uart_mmio #(.DEFAULT_DIV(217), .RX_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_div = 4;

  typedef struct packed {
    logic [7:0] b;
    int         start;
    logic       b2b;
    logic       abort;
  } tx_exp_t;

  logic [32:0] bus_q[$];
  string       bus_nm_q[$];
  tx_exp_t     tx_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [3:0] w, input logic [1:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string nm, output int rc);
    int n;
    bus_q.push_back({chk, exp});
    bus_nm_q.push_back(nm);
    @(posedge clk); #1;
    cs = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 4);
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_timeout %s: got no ready after %0d cycles expected ready", nm, n);
      void'(bus_q.pop_back());
      void'(bus_nm_q.pop_back());
    end
    rc = cyc;
    @(posedge clk); #1;
    cs = 1'b0; we = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    int rc;
    bus(4'b0000, a, 32'h0, 1'b1, exp, nm, rc);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d, output int rc);
    bus(w, a, d, 1'b0, 32'h0, "write", rc);
  endtask

  task automatic tx_expect(input logic [7:0] b, input int start, input logic b2b, input logic abort);
    tx_exp_t e;
    e.b = b; e.start = start; e.b2b = b2b; e.abort = abort;
    tx_q.push_back(e);
  endtask

  task automatic hold_rxd(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int dv);
    @(posedge clk); #1;
    hold_rxd(1'b0, dv);
    for (int i = 0; i < 8; i++) hold_rxd(b[i], dv);
    hold_rxd(stop_bit, dv);
    rxd = 1'b1;
  endtask

  // Bus monitor: ready must follow a cs rise by exactly one cycle; read data compared on ready.
  initial begin : bus_mon
    logic prev_cs, prev_rdy, exp_r;
    logic [32:0] e;
    string nm;
    prev_cs = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      exp_r = prev_cs && !prev_rdy && rst_n;
      if (ready || exp_r) check("ready_pulse", {31'h0, ready}, {31'h0, exp_r});
      if (ready) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected_ready: got ready with rdata %h expected no access", rdata);
        end else begin
          e = bus_q.pop_front();
          nm = bus_nm_q.pop_front();
          if (e[32]) check(nm, rdata, e[31:0]);
        end
      end
      prev_cs = cs;
      prev_rdy = ready;
    end
  end

  // TX monitor: captures each frame cycle by cycle from its falling start edge.
  initial begin : tx_mon
    logic prev;
    logic [9:0] fb;
    tx_exp_t e;
    int s, bad, last_s;
    bit have;
    prev = 1'b1;
    last_s = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !txd) begin
        s = cyc;
        have = (tx_q.size() > 0);
        if (have) e = tx_q.pop_front();
        else e = '0;
        fb = {1'b1, e.b, 1'b0};
        bad = 0;
        for (int i = 0; i < 10 * mon_div; i++) begin
          if (i > 0) @(negedge clk);
          if (txd !== fb[i / mon_div]) bad++;
        end
        prev = txd;
        if (!have) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected_frame: got frame at cycle %0d expected none", s);
        end else if (!e.abort) begin
          check("tx_frame_bits", bad, 0);
          if (e.start >= 0) check("tx_start_cycle", s, e.start);
          if (e.b2b) check("tx_back_to_back", s, last_s + 10 * mon_div);
        end
        last_s = s;
      end else begin
        prev = txd;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rc;
    rst_n = 1'b1; cs = 1'b0; we = '0; addr = '0; wdata = '0; rxd = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    check("rst_txd", {31'h0, txd}, 32'h1);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    rd(2'd2, 32'd217, "div_reset");
    rd(2'd1, 32'h0, "status_reset");
    rd(2'd3, 32'h0, "reserved_read");
    rd(2'd0, 32'hFFFF_FFFF, "data_empty");
    wr(2'd2, 4'b0011, 32'd2, rc);
    rd(2'd2, 32'd4, "div_min_clamp");
    wr(2'd2, 4'b0001, 32'h0000_FF09, rc);
    rd(2'd2, 32'd9, "div_low_byte");
    wr(2'd3, 4'b1111, 32'hDEAD_BEEF, rc);
    rd(2'd3, 32'h0, "reserved_write");
    wr(2'd2, 4'b0011, 32'd4, rc);
    mon_div = 4;

    // Single frame 0x55 at DIV=4.
    wr(2'd0, 4'b0001, 32'h55, rc);
    tx_expect(8'h55, rc + 2, 1'b0, 1'b0);
    rd(2'd1, 32'h1, "status_tx_busy");
    repeat (45) @(posedge clk);
    rd(2'd1, 32'h0, "status_tx_done");

    // Back-to-back frames; third write while holding is full must vanish.
    wr(2'd0, 4'b0001, 32'h01, rc);
    tx_expect(8'h01, rc + 2, 1'b0, 1'b0);
    wr(2'd0, 4'b0001, 32'h02, rc);
    tx_expect(8'h02, -1, 1'b1, 1'b0);
    rd(2'd1, 32'h3, "status_tx_full");
    wr(2'd0, 4'b0001, 32'h03, rc);
    repeat (100) @(posedge clk);
    rd(2'd1, 32'h0, "status_tx_idle2");

    // Receive path at DIV=8.
    wr(2'd2, 4'b0011, 32'd8, rc);
    send_frame(8'hA5, 1'b1, 8);
    repeat (16) @(posedge clk);
    rd(2'd1, 32'h4, "status_rx_valid");
    rd(2'd0, 32'h0000_00A5, "rx_a5");
    rd(2'd0, 32'hFFFF_FFFF, "rx_empty_after_pop");

    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b1, 8);
    repeat (16) @(posedge clk);
    rd(2'd1, 32'hC, "status_overrun");
    rd(2'd0, 32'h11, "rx_fifo0");
    rd(2'd0, 32'h22, "rx_fifo1");
    rd(2'd0, 32'h33, "rx_fifo2");
    rd(2'd0, 32'h44, "rx_fifo3");
    rd(2'd0, 32'hFFFF_FFFF, "rx_fifo_drained");
    wr(2'd1, 4'b0001, 32'h8, rc);
    rd(2'd1, 32'h0, "overrun_cleared");

    send_frame(8'h3C, 1'b0, 8);
    repeat (16) @(posedge clk);
    rd(2'd1, 32'h10, "status_frame_err");
    rd(2'd0, 32'hFFFF_FFFF, "ferr_fifo_empty");
    wr(2'd1, 4'b0001, 32'h8, rc);
    rd(2'd1, 32'h10, "ferr_kept");
    wr(2'd1, 4'b0001, 32'h10, rc);
    rd(2'd1, 32'h0, "ferr_cleared");

    @(posedge clk); #1;
    hold_rxd(1'b0, 2);
    rxd = 1'b1;
    repeat (100) @(posedge clk);
    rd(2'd1, 32'h0, "glitch_no_flag");
    rd(2'd0, 32'hFFFF_FFFF, "glitch_no_byte");

    // Reset in the middle of a transmitted frame.
    wr(2'd2, 4'b0011, 32'd4, rc);
    wr(2'd0, 4'b0001, 32'h00, rc);
    tx_expect(8'h00, -1, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midframe_rst_txd", {31'h0, txd}, 32'h1);
    check("midframe_rst_ready", {31'h0, ready}, 32'h0);
    check("midframe_rst_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rd(2'd2, 32'd217, "div_after_rst");
    rd(2'd1, 32'h0, "status_after_rst");
    rd(2'd0, 32'hFFFF_FFFF, "data_after_rst");

    repeat (60) @(posedge clk);
    check("bus_sb_drained", bus_q.size(), 0);
    check("tx_sb_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
